// File: rtl/multi_channel_patgen.sv
// multi_channel_patgen: NCH independent pulse-set generators sharing one config port, suspend and sync input.
// Define MULTI_CHANNEL_PATGEN_READBACK_EN to add a registered config/status read port.
module multi_channel_patgen #(
  parameter int NCH = 4,
  parameter int CNT_W = 16,
  localparam int CH_AW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             resn,
  input  logic             suspend,
  input  logic             syncrst,
  input  logic             cfg_write,
  input  logic [CH_AW+2:0] cfg_address,
  input  logic [CNT_W-1:0] cfg_data,
`ifdef MULTI_CHANNEL_PATGEN_READBACK_EN
  input  logic [CH_AW+2:0] cfg_read_address,
  output logic [CNT_W-1:0] cfg_read_data,
`endif
  output logic [NCH-1:0]   out,
  output logic [NCH-1:0]   running,
  output logic [NCH-1:0]   done
);
  typedef enum logic [2:0] {IDLE, WAIT_SYNC, DELAY, HIGH, LOW, DONE} state_t;
  logic [2:0] sync_q;
  logic sync_edge;
  logic [CH_AW-1:0] wr_ch;
  logic [2:0] wr_reg;
  assign {wr_ch, wr_reg} = cfg_address;
  assign sync_edge = sync_q[1] & ~sync_q[2];
  always_ff @(posedge clk or negedge resn)
    if (!resn) sync_q <= '0;
    else sync_q <= {sync_q[1:0], syncrst};
`ifdef MULTI_CHANNEL_PATGEN_READBACK_EN
  logic [CNT_W-1:0] rb [NCH][8];
  logic [CH_AW-1:0] rd_ch;
  assign rd_ch = cfg_read_address[CH_AW+2:3];
  always_ff @(posedge clk or negedge resn)
    if (!resn) cfg_read_data <= '0;
    else cfg_read_data <= (int'(rd_ch) < NCH) ? rb[rd_ch][cfg_read_address[2:0]] : '0;
`endif
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t state, nstate;
    logic [CNT_W-1:0] numpulses, period, runlen, idelay, clkfac;
    logic [CNT_W-1:0] l_per_m1, l_clkfac, div, cnt, prem, sets;
    logic synced, done_q, sel, arm, abort, tick, expire, start, end_set, set_last;
    assign sel = cfg_write && wr_ch == CH_AW'(c);
    assign arm = sel && wr_reg == 3'd5 && cfg_data[1];
    assign abort = sel && wr_reg == 3'd5 && !cfg_data[1];
    assign tick = div == '0;
    assign expire = tick && cnt == '0;
    assign set_last = runlen != '0 && sets + CNT_W'(1) >= runlen;
    assign out[c] = state == HIGH;
    assign running[c] = state inside {DELAY, HIGH, LOW};
    assign done[c] = done_q;
`ifdef MULTI_CHANNEL_PATGEN_READBACK_EN
    assign rb[c] = '{numpulses, period, runlen, idelay, clkfac,
                     CNT_W'({done_q, running[c], synced}), sets, CNT_W'(state)};
`endif
    always_comb begin
      nstate = state;
      start = 1'b0;
      end_set = 1'b0;
      if (arm) begin
        nstate = cfg_data[0] ? WAIT_SYNC : DELAY;
        start = !cfg_data[0];
      end else if (abort) nstate = IDLE;
      else if (!suspend)
        case (state)
          WAIT_SYNC: begin
            nstate = sync_edge ? DELAY : WAIT_SYNC;
            start = sync_edge;
          end
          DELAY: nstate = expire ? HIGH : DELAY;
          HIGH: begin
            nstate = expire ? LOW : HIGH;
            end_set = expire && prem <= CNT_W'(1);
          end
          LOW: nstate = expire ? HIGH : LOW;
          default: ;
        endcase
      if (end_set) begin
        nstate = set_last ? DONE : synced ? WAIT_SYNC : DELAY;
        start = !set_last && !synced;
      end
    end
    always_ff @(posedge clk or negedge resn)
      if (!resn) begin
        state <= IDLE;
        numpulses <= '0;
        period <= '0;
        runlen <= '0;
        idelay <= '0;
        clkfac <= '0;
        synced <= 1'b0;
        done_q <= 1'b0;
        l_per_m1 <= '0;
        l_clkfac <= '0;
        div <= '0;
        cnt <= '0;
        prem <= '0;
        sets <= '0;
      end else begin
        state <= nstate;
        if (sel)
          case (wr_reg)
            3'd0: numpulses <= cfg_data;
            3'd1: period <= cfg_data;
            3'd2: runlen <= cfg_data;
            3'd3: idelay <= cfg_data;
            3'd4: clkfac <= cfg_data;
            3'd5: synced <= cfg_data[0];
            default: ;
          endcase
        if (arm) begin
          done_q <= 1'b0;
          sets <= '0;
        end else if (end_set) begin
          sets <= sets + CNT_W'(1);
          if (set_last) done_q <= 1'b1;
        end
        // set start snapshots timing config so mid-set writes only affect the next set
        if (start) begin
          l_per_m1 <= (period == '0) ? '0 : period - CNT_W'(1);
          l_clkfac <= clkfac;
          div <= clkfac;
          cnt <= idelay;
          prem <= (numpulses == '0) ? CNT_W'(1) : numpulses;
        end else if (!suspend && running[c]) begin
          div <= tick ? l_clkfac : div - CNT_W'(1);
          if (tick) cnt <= (cnt == '0) ? l_per_m1 : cnt - CNT_W'(1);
          if (state == LOW && expire) prem <= prem - CNT_W'(1);
        end
      end
  end
endmodule

// File: doc/multi_channel_patgen.md
Name: multi_channel_patgen

Overview:
- N-channel successor to the single-channel sync/async injection pattern generator.
- Each channel has its own config registers, clock divider, pulse-set state machine and output.
- All channels share one register-write port, one suspend input and one external sync input.
- Sits between the register-file decoder and the chip injection/trigger pins; lets several injection lines be driven with independent timing in one run.

Parameters:
- NCH, 4: number of channels, 1..16. Internal CH_AW = max(1, $clog2(NCH)).
- CNT_W, 16: width of every config register and counter.

Ports:
- clk  in  1  single system clock.
- resn  in  1  asynchronous active-low reset.
- suspend  in  1  high: every channel freezes state, all counters and divider; out holds.
- syncrst  in  1  external sync. Asynchronous to clk; 2-flop synchronised inside, then rising-edge detected.
- cfg_write  in  1  write strobe, one cycle.
- cfg_address  in  CH_AW+3  {channel, reg}; reg index 0..7.
- cfg_data  in  CNT_W  write data.
- out  out  NCH  pattern outputs.
- running  out  NCH  channel is between sync/arm and end of the current pulse set.
- done  out  NCH  channel finished its RUNLEN sets.

Behaviour:
- Reset (resn low, asynchronous):
  - all config registers = 0; all channels IDLE.
  - out, running, done = 0; sync flops = 0.
- Register map per channel:
  - 0 NUMPULSES: 0 is treated as 1.
  - 1 PERIOD: ticks; 0 is treated as 1.
  - 2 RUNLEN: 0 = infinite.
  - 3 IDELAY: ticks.
  - 4 CLKFAC: tick every CLKFAC+1 clk cycles.
  - 5 CTRL: bit0 SYNCED, bit1 ARM. Bit1 is a strobe, not stored.
  - 6, 7: reserved; writes ignored.
- Address handling: channel index >= NCH ignored. Writes take effect on the next edge.
- CTRL write with ARM=1:
  - clears done, loads set counter.
  - enters WAIT_SYNC if SYNCED=1, otherwise DELAY.
  - an ARM while already active restarts the channel.
- CTRL write with ARM=0: abort. IDLE, out=0, running=0, done unchanged.
- Tick: divider is loaded with CLKFAC on entry to DELAY; a tick occurs when the divider is 0, then it reloads.
- States:
  - IDLE: out=0, running=0.
  - WAIT_SYNC: running=0. A synchronised syncrst rising edge enters DELAY and sets running=1. Edges in any other state are ignored.
  - DELAY: running=1. Delay counter loaded with IDELAY on entry. On a tick: if 0, go to HIGH with out=1; else decrement.
  - HIGH: pulse counter loaded with PERIOD-1 on entry; decremented on each tick. At 0 on a tick:
    - if pulses remaining > 1: go to LOW, out=0;
    - otherwise end the set.
  - LOW: same counting as HIGH, then back to HIGH with out=1 and pulses remaining decremented.
  - DONE: out=0, running=0, done=1. Stays until ARM or reset.
- Resulting timing:
  - out high for exactly PERIOD*(CLKFAC+1) clk per pulse; same length low between pulses.
  - first rise (IDELAY+1)*(CLKFAC+1) clk after entering DELAY.
- End of set:
  - out=0, running=0.
  - If not infinite and the set counter has reached RUNLEN: DONE.
  - Else: WAIT_SYNC if SYNCED, otherwise DELAY again (IDELAY doubles as off-time in async mode).
- Config latching: PERIOD, NUMPULSES, IDELAY and CLKFAC are latched at each set start (DELAY entry). Writes mid-set apply from the next set.
- Suspend:
  - blocks state and counter updates, including sync-edge capture; the synchroniser keeps shifting.
  - register writes still land.
- Suspend and ARM in the same cycle: ARM applies.
- Channels are fully independent; simultaneous writes cannot occur (single port).

Optional Feature:
- Macro: MULTI_CHANNEL_PATGEN_READBACK_EN.
- Defined: adds ports cfg_read_address in CH_AW+3 and cfg_read_data out CNT_W.
  - Registered read, 1-cycle latency.
  - reg 0-4 return config values; reg 5 returns {done, running, SYNCED}.
  - reg 6 returns completed-set count; reg 7 returns current state code.
  - Out-of-range channel reads 0.
- Undefined: ports absent, no readback logic.

Test Plan:
- Ch0 async, CLKFAC=0, IDELAY=2, PERIOD=3, NUMPULSES=1, RUNLEN=2, ARM -> out high 3 cycles, first rise 3 cycles after DELAY entry; low 3 cycles; second 3-cycle pulse; then done[0]=1.
- Ch1 synced, NUMPULSES=3, PERIOD=2, CLKFAC=1, RUNLEN=1, ARM, no syncrst -> running=0, out=0; one syncrst pulse -> 3 pulses of 4 clk high / 4 low, then done[1]=1.
- Ch2 RUNLEN=0 async -> pulses continue indefinitely; CTRL ARM=0 mid-pulse -> out=0 next cycle, done=0.
- Suspend asserted 10 cycles mid-HIGH on ch0 -> out high 10 cycles longer; pulse width otherwise unchanged.
- resn asserted mid-run on all channels -> out/running/done = 0 immediately without a clock; config reads back 0 (readback build).
- Write PERIOD=5 to ch0 during set 1 of RUNLEN=2 -> set 1 keeps old width, set 2 uses 5 ticks; write to channel NCH ignored.
